// File: rtl/pipe_stage_reg_pkg.sv
// Shared CPU pipeline constants and the pipeline-stage register FSM encoding.
package pipe_stage_reg_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned ExcW     = 5;
  localparam logic [4:0]  ExcNone  = 5'd0;
  localparam logic [31:0] ResetPc  = 32'h0000_3000;

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StFull  = 2'd1,
    StHeld  = 2'd2
  } pipe_state_e;

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Up-counter that sticks at all-ones; clear wins over increment.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (inc && (q_q != '1)) begin
      q_d = q_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with stall/flush, occupancy FSM and stall/bubble statistics.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int unsigned     PC_W      = 32,
  parameter int unsigned     DATA_W    = 32,
  parameter int unsigned     EXC_W     = 5,
  parameter logic [PC_W-1:0] RESET_PC  = PC_W'(ResetPc),
  parameter int unsigned     CNT_W     = 16,
  parameter int unsigned     MAX_STALL = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stopen,
  input  logic              flush,
  input  logic              valid_in,
  input  logic [PC_W-1:0]   pc_in,
  input  logic [DATA_W-1:0] instr_in,
  input  logic [EXC_W-1:0]  exc_in,
  input  logic              bd_in,
  output logic              valid_out,
  output logic [PC_W-1:0]   pc_out,
  output logic [DATA_W-1:0] instr_out,
  output logic [EXC_W-1:0]  exc_out,
  output logic              bd_out,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic              stall_timeout
);

  localparam int unsigned PayW    = 1 + PC_W + DATA_W + EXC_W + 1;
  localparam int unsigned TailW   = DATA_W + EXC_W + 1;
  localparam int unsigned ConsW   = $clog2(MAX_STALL + 1);
  localparam logic [ConsW-1:0] MaxStallC = ConsW'(MAX_STALL);
  localparam logic [PayW-1:0]  PayReset  = {1'b0, RESET_PC, {TailW{1'b0}}};

  // {valid, pc, instr, exc, bd}
  logic [PayW-1:0]  payload_q, payload_d;
  pipe_state_e      state_q, state_d;
  pipe_state_e      load_state;
  logic             timeout_q, timeout_d;
  logic [ConsW-1:0] cons_cnt;
  logic             stall;

  assign stall      = stopen & ~flush;
  assign load_state = valid_in ? StFull : StEmpty;

  always_comb begin
    payload_d = payload_q;
    state_d   = state_q;
    if (flush) begin
      // Bubble keeps the incoming PC so a later exception reports the right EPC.
      payload_d = {1'b0, pc_in, {TailW{1'b0}}};
      state_d   = StEmpty;
    end else begin
      if (!stopen) begin
        payload_d = {valid_in, pc_in, instr_in, exc_in, bd_in};
      end
      unique case (state_q)
        StEmpty, StFull: state_d = stall ? StHeld : load_state;
        StHeld:          state_d = stopen ? StHeld : load_state;
        default:         state_d = StEmpty;
      endcase
    end
  end

  // Registered so the flag rises on the same edge the consecutive count reaches the limit.
  assign timeout_d = stall && (cons_cnt >= (MaxStallC - ConsW'(1)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      payload_q <= PayReset;
      state_q   <= StEmpty;
      timeout_q <= 1'b0;
    end else begin
      payload_q <= payload_d;
      state_q   <= state_d;
      timeout_q <= timeout_d;
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (stall),
    .clr  (1'b0),
    .q    (stall_cnt)
  );

  sat_counter #(
    .W(CNT_W)
  ) u_bubble_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (flush),
    .clr  (1'b0),
    .q    (bubble_cnt)
  );

  sat_counter #(
    .W(ConsW)
  ) u_cons_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (stall && (cons_cnt != MaxStallC)),
    .clr  (~stall),
    .q    (cons_cnt)
  );

  assign {valid_out, pc_out, instr_out, exc_out, bd_out} = payload_q;
  assign stall_timeout = timeout_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: scoreboarded vector table plus reset/timeout sequences.
module tb_pipe_stage_reg;
  import pipe_stage_reg_pkg::*;

  typedef struct {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  exc;
    logic        bd;
    logic [15:0] sc;
    logic [15:0] bc;
    logic        to;
  } exp_t;

  typedef struct {
    logic        flush;
    logic        stopen;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  exc;
    logic        bd;
    exp_t        e;
  } vec_t;

  logic clk = 1'b1;
  logic reset, stopen, flush, valid_in, bd_in;
  logic [31:0] pc_in, instr_in;
  logic [4:0]  exc_in;

  logic        valid_out, bd_out, stall_timeout;
  logic [31:0] pc_out, instr_out;
  logic [4:0]  exc_out;
  logic [15:0] stall_cnt, bubble_cnt;

  logic        s_valid, s_bd, s_to;
  logic [31:0] s_pc, s_instr;
  logic [4:0]  s_exc;
  logic [1:0]  s_sc, s_bc;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];
  vec_t tbl[8];

  always #5 clk = ~clk;

  pipe_stage_reg dut (
    .clk(clk), .reset(reset), .stopen(stopen), .flush(flush), .valid_in(valid_in),
    .pc_in(pc_in), .instr_in(instr_in), .exc_in(exc_in), .bd_in(bd_in),
    .valid_out(valid_out), .pc_out(pc_out), .instr_out(instr_out), .exc_out(exc_out),
    .bd_out(bd_out), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt),
    .stall_timeout(stall_timeout)
  );

  pipe_stage_reg #(
    .CNT_W(2),
    .MAX_STALL(4)
  ) dut_s (
    .clk(clk), .reset(reset), .stopen(stopen), .flush(flush), .valid_in(valid_in),
    .pc_in(pc_in), .instr_in(instr_in), .exc_in(exc_in), .bd_in(bd_in),
    .valid_out(s_valid), .pc_out(s_pc), .instr_out(s_instr), .exc_out(s_exc),
    .bd_out(s_bd), .stall_cnt(s_sc), .bubble_cnt(s_bc), .stall_timeout(s_to)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t ex(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                              input logic [4:0] exc, input logic bd, input logic [15:0] sc,
                              input logic [15:0] bc);
    exp_t e;
    e.valid = v; e.pc = pc; e.instr = ins; e.exc = exc; e.bd = bd;
    e.sc = sc; e.bc = bc; e.to = 1'b0;
    return e;
  endfunction

  function automatic vec_t mk(input logic f, input logic s, input logic v, input logic [31:0] pc,
                              input logic [31:0] ins, input logic [4:0] exc, input logic bd,
                              input exp_t e);
    vec_t r;
    r.flush = f; r.stopen = s; r.valid = v; r.pc = pc; r.instr = ins; r.exc = exc; r.bd = bd;
    r.e = e;
    return r;
  endfunction

  task automatic drive(input vec_t v);
    flush = v.flush; stopen = v.stopen; valid_in = v.valid;
    pc_in = v.pc; instr_in = v.instr; exc_in = v.exc; bd_in = v.bd;
    sb.push_back(v.e);
  endtask

  task automatic tick(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: scoreboard empty, got pc=%0h expected an entry", tag, pc_out);
    end else begin
      e = sb.pop_front();
      chk({tag, ".valid"}, valid_out, e.valid);
      chk({tag, ".pc"}, pc_out, e.pc);
      chk({tag, ".instr"}, instr_out, e.instr);
      chk({tag, ".exc"}, exc_out, e.exc);
      chk({tag, ".bd"}, bd_out, e.bd);
      chk({tag, ".stall_cnt"}, stall_cnt, e.sc);
      chk({tag, ".bubble_cnt"}, bubble_cnt, e.bc);
      chk({tag, ".timeout"}, stall_timeout, e.to);
    end
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0; stopen = 1'b0; flush = 1'b0; valid_in = 1'b0; bd_in = 1'b0;
    pc_in = '0; instr_in = '0; exc_in = '0;

    // Continues from the state left by the hand sequences: stall_cnt=3, bubble_cnt=1.
    tbl[0] = mk(0, 0, 1, 32'h400, 32'hDEAD_BEEF, 5'h0a, 1,
                ex(1, 32'h400, 32'hDEAD_BEEF, 5'h0a, 1, 3, 1));
    tbl[1] = mk(0, 0, 0, 32'h404, 32'h1111_1111, 5'h03, 0,
                ex(0, 32'h404, 32'h1111_1111, 5'h03, 0, 3, 1));
    tbl[2] = mk(0, 0, 1, 32'h408, 32'h8C22_0004, 5'h00, 0,
                ex(1, 32'h408, 32'h8C22_0004, 5'h00, 0, 3, 1));
    tbl[3] = mk(0, 1, 0, 32'h500, 32'h0, 5'h01, 1,
                ex(1, 32'h408, 32'h8C22_0004, 5'h00, 0, 4, 1));
    tbl[4] = mk(1, 0, 1, 32'h50c, 32'hFFFF_FFFF, 5'h1f, 1,
                ex(0, 32'h50c, 32'h0, 5'h00, 0, 4, 2));
    tbl[5] = mk(0, 0, 1, 32'h510, 32'h1234_5678, 5'h1f, 1,
                ex(1, 32'h510, 32'h1234_5678, 5'h1f, 1, 4, 2));
    tbl[6] = mk(1, 1, 1, 32'h514, 32'hAAAA_5555, 5'h02, 1,
                ex(0, 32'h514, 32'h0, 5'h00, 0, 4, 3));
    tbl[7] = mk(0, 1, 1, 32'h600, 32'h7777_7777, 5'h04, 0,
                ex(0, 32'h514, 32'h0, 5'h00, 0, 5, 3));

    // Reset asserted mid-cycle takes effect before any clock edge.
    #5 reset = 1'b1;
    #1;
    chk("rst.pc", pc_out, 32'h3000);
    chk("rst.valid", valid_out, 1'b0);
    chk("rst.instr", instr_out, 32'h0);
    chk("rst.cnts", {stall_cnt, bubble_cnt}, 32'h0);
    chk("rst.timeout", stall_timeout, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    // Single-cycle load latency.
    drive(mk(0, 0, 1, 32'h3004, 32'h2408_0001, 5'h0, 0,
             ex(1, 32'h3004, 32'h2408_0001, 5'h0, 0, 0, 0)));
    #1;
    chk("load.pre_edge_valid", valid_out, 1'b0);
    tick("load");
    chk("load.state", dut.state_q, StFull);

    // Three stall cycles with a moving upstream PC.
    for (int k = 1; k <= 3; k++) begin
      drive(mk(0, 1, 1, 32'h3004 + 32'(4 * k), 32'hCAFE_0000 + 32'(k), 5'h0, 0,
               ex(1, 32'h3004, 32'h2408_0001, 5'h0, 0, 16'(k), 0)));
      tick("stall");
    end
    chk("stall.state", dut.state_q, StHeld);

    // Flush together with stall acts as flush only.
    drive(mk(1, 1, 1, 32'h3008, 32'h2408_0002, 5'h3, 1,
             ex(0, 32'h3008, 32'h0, 5'h0, 0, 3, 1)));
    tick("stall_flush");
    chk("stall_flush.state", dut.state_q, StEmpty);

    for (int i = 0; i < 8; i++) begin
      drive(tbl[i]);
      tick($sformatf("vec%0d", i));
    end

    // Reset during a combined stall+flush overrides both, across a clock edge.
    stopen = 1'b1; flush = 1'b1; pc_in = 32'h777; reset = 1'b1;
    #1;
    chk("rst_mid.pc", pc_out, 32'h3000);
    chk("rst_mid.cnts", {stall_cnt, bubble_cnt}, 32'h0);
    @(posedge clk);
    #1;
    chk("rst_hold.pc", pc_out, 32'h3000);
    chk("rst_hold.bubble", bubble_cnt, 16'h0);
    @(negedge clk);
    reset = 1'b0;
    drive(mk(0, 1, 1, 32'h888, 32'h9999_9999, 5'h1, 1,
             ex(0, 32'h3000, 32'h0, 5'h0, 0, 1, 0)));
    tick("post_rst");

    // Small-parameter instance: timeout at 4 consecutive stalls, 2-bit counters saturate.
    reset = 1'b1;
    #1;
    reset = 1'b0;
    stopen = 1'b1; flush = 1'b0; valid_in = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("to.edge%0d", k), s_to, (k >= 4));
      chk($sformatf("sat.edge%0d", k), s_sc, (k >= 3) ? 2'd3 : 2'(k));
      chk($sformatf("sat_nz.edge%0d", k), (s_sc != 2'd0), 1'b1);
      @(negedge clk);
    end
    stopen = 1'b0;
    @(posedge clk);
    #1;
    chk("to.release", s_to, 1'b0);
    chk("sat.release", s_sc, 2'd3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter PC_W, default 32, PC field width.
REQ-002 Parameter DATA_W, default 32, instruction field width.
REQ-003 Parameter EXC_W, default 5, exception-code field width.
REQ-004 Parameter RESET_PC, default 32'h0000_3000, pc_out value after reset.
REQ-005 Parameter CNT_W, default 16, width of the performance counters.
REQ-006 Parameter MAX_STALL, default 255, consecutive-stall limit for the timeout flag.
REQ-007 clk  in  1  sole clock; all state updates on its rising edge.
REQ-008 reset  in  1  asynchronous, active-high reset.
REQ-009 stopen  in  1  stall: hold all payload registers.
REQ-010 flush  in  1  insert a bubble: clear payload, keep PC.
REQ-011 valid_in  in  1  upstream slot holds a real instruction.
REQ-012 pc_in  in  PC_W  upstream PC.
REQ-013 instr_in  in  DATA_W  upstream instruction word.
REQ-014 exc_in  in  EXC_W  upstream exception code; 0 means none.
REQ-015 bd_in  in  1  upstream instruction is in a branch-delay slot.
REQ-016 valid_out, pc_out, instr_out, exc_out, bd_out  out  1/PC_W/DATA_W/EXC_W/1  registered copies of the inputs.
REQ-017 stall_cnt  out  CNT_W  total cycles with stopen=1 and flush=0.
REQ-018 bubble_cnt  out  CNT_W  total flush cycles.
REQ-019 stall_timeout  out  1  consecutive stalls have reached MAX_STALL.

Function
REQ-020 Priority on each edge SHALL be: reset > flush > stopen > load.
REQ-021 Load (flush=0, stopen=0): all payload outputs SHALL take the input values one cycle later; latency is exactly 1 cycle.
REQ-022 Stall (stopen=1, flush=0): all payload outputs SHALL hold their values.
REQ-023 Flush: valid_out, instr_out, exc_out and bd_out SHALL clear to 0; pc_out SHALL load pc_in so a bubble carries the correct EPC.
REQ-024 Flush and stopen asserted together SHALL behave as flush; the stall counters SHALL NOT increment.
REQ-025 The FSM SHALL have three states: EMPTY (valid_out=0), FULL (valid_out=1, not stalled), HELD (stalled).
REQ-026 EMPTY/FULL SHALL go to HELD on stopen=1 with flush=0.
REQ-027 On load, the FSM SHALL go to FULL if valid_in=1 and to EMPTY otherwise.
REQ-028 Any state SHALL go to EMPTY on flush.
REQ-029 HELD SHALL stay in HELD while stopen=1 and SHALL leave on stopen=0 (load rule applies).
REQ-030 A consecutive-stall counter SHALL increment each cycle in HELD and clear on leaving HELD.
REQ-031 stall_timeout SHALL be 1 whenever the consecutive count is ≥ MAX_STALL; the count SHALL saturate at MAX_STALL.
REQ-032 stall_cnt and bubble_cnt SHALL saturate at all-ones and never wrap.
REQ-033 All outputs SHALL be driven directly from registers, with no combinational input-to-output path.

Reset
REQ-034 Asserting reset SHALL immediately set: pc_out=RESET_PC, valid_out=0, instr_out=0, exc_out=0, bd_out=0, FSM=EMPTY, all counters=0, stall_timeout=0.
REQ-035 Reset asserted mid-stall or mid-flush SHALL override both; the first edge after deassertion SHALL follow REQ-020.

Structure
REQ-036 The FSM state encoding and the RESET_PC default SHALL live in the shared CPU package alongside the existing pipeline constants.
REQ-037 The saturating counter SHALL be one sub-module, sat_counter (parameter W; ports clk, reset, inc, clr, q), instantiated three times.
REQ-038 Payload registers SHALL be a single concatenated vector driven by one always block.

Verification
REQ-039 Reset: assert reset at t=5 ns mid-cycle -> pc_out=32'h3000 and valid_out=0 before the next edge.
REQ-040 Load: pc_in=32'h3004, instr_in=32'h2408_0001, valid_in=1 -> exactly one edge later, outputs match and state=FULL.
REQ-041 Stall: stopen=1 for 3 cycles while pc_in changes -> pc_out holds 32'h3004 and stall_cnt=3.
REQ-042 Stall plus flush: stopen=1 and flush=1 with pc_in=32'h3008 -> valid_out=0, instr_out=0, pc_out=32'h3008, bubble_cnt+1, stall_cnt unchanged.
REQ-043 Timeout: with MAX_STALL=4, hold stopen=1 for 6 cycles -> stall_timeout rises after the 4th edge, stays high, and drops on the first edge with stopen=0.
REQ-044 Saturation: with CNT_W=2, stall 5 cycles -> stall_cnt=3, never 0.
